// File: rtl/bus_xfer_sched.sv
// bus_xfer_sched: round-robin sequencer for the shared 16-bit tri-state data bus.
// It grants one source per XFER cycle and always follows it with a dead TURN cycle.
module bus_xfer_sched #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*IW-1:0] dst,
    output logic [N-1:0]    rd_en,
    output logic [N-1:0]    wr_en,
    output logic [N-1:0]    done,
    output logic            err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] src_q, src_d;
    logic [IW-1:0] dst_q, dst_d;
    logic [IW-1:0] win;

    logic [N-1:0]  rd_en_q, rd_en_d;
    logic [N-1:0]  wr_en_q, wr_en_d;
    logic [N-1:0]  done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    // First set request at or after the pointer, wrapping modulo N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic [IW-1:0] cand;
        logic          found;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(p) + k) % N);
            if (!found && r[cand]) begin
                w     = cand;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win = rr_pick(req, ptr_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            rd_en_q <= '0;
            wr_en_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        dst_d   = dst_q;
        unique case (state_q)
            IDLE, TURN: begin
                if (|req) begin
                    state_d = XFER;
                    src_d   = win;
                    dst_d   = dst[int'(win)*IW +: IW];
                    ptr_d   = (int'(win) == N - 1) ? '0 : win + IW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            XFER:    state_d = TURN;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops and appear
    // during the cycle the FSM occupies that state.
    always_comb begin
        rd_en_d = '0;
        wr_en_d = '0;
        done_d  = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        if (state_d == XFER) begin
            busy_d        = 1'b1;
            done_d[src_d] = 1'b1;
            if (dst_d == src_d) begin
                err_d = 1'b1;
            end else begin
                rd_en_d[src_d] = 1'b1;
                wr_en_d[dst_d] = 1'b1;
            end
        end else if (state_d == TURN) begin
            busy_d = 1'b1;
        end
    end

    assign rd_en = rd_en_q;
    assign wr_en = wr_en_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Testbench for bus_xfer_sched: bus units modeled as 16-bit registers, a round-robin
// reference model feeds a scoreboard that a negedge monitor drains on every done pulse.
module tb_bus_xfer_sched;

    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        int src;
        int dst;
        bit rej;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*IW-1:0] dst;
    logic [N-1:0]    rd_en;
    logic [N-1:0]    wr_en;
    logic [N-1:0]    done;
    logic            err;
    logic            busy;

    logic [15:0]     unit_q [N];
    logic [15:0]     ref_mem [N];
    logic [15:0]     bus_val;
    logic            bus_driven;
    logic            load_en;
    logic [IW-1:0]   load_idx;
    logic [15:0]     load_val;

    logic [IW-1:0]   dst_arr [N];
    logic [N-1:0]    drop_pending;
    bit              sticky;
    int              model_ptr;
    int              cyc;
    int              tests;
    int              failures;
    exp_t            exp_q [$];
    int              done_cyc [$];

    bus_xfer_sched #(.N(N), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .dst   (dst),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .done  (done),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The enabled source drives the bus; everyone with write set captures it at the edge.
    always_comb begin
        bus_val    = 16'h0000;
        bus_driven = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rd_en[i]) begin
                bus_val    = bus_val | unit_q[i];
                bus_driven = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (load_en) begin
            unit_q[load_idx] <= load_val;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (wr_en[j]) unit_q[j] <= bus_val;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (drop_pending[i]) begin
                if (!sticky) req[i] = 1'b0;
                drop_pending[i] = 1'b0;
            end
        end
    endtask

    task automatic load_unit(input int idx, input logic [15:0] val);
        load_en      = 1'b1;
        load_idx     = IW'(idx);
        load_val     = val;
        ref_mem[idx] = val;
        step();
        load_en = 1'b0;
    endtask

    // Reference model: repeatedly grant the first pending requester at or after the pointer.
    task automatic issue(input logic [N-1:0] mask, input int count);
        logic [N-1:0] pending;
        exp_t         e;
        int           w;
        bit           found;
        pending = mask;
        for (int n = 0; n < count; n++) begin
            found = 0;
            w     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && pending[(model_ptr + k) % N]) begin
                    w     = (model_ptr + k) % N;
                    found = 1;
                end
            end
            if (found) begin
                e.src = w;
                e.dst = int'(dst_arr[w]);
                e.rej = (e.dst == e.src);
                exp_q.push_back(e);
                model_ptr = (w + 1) % N;
                if (!sticky) pending[w] = 1'b0;
            end
        end
    endtask

    task automatic set_dst(input int d0, input int d1, input int d2, input int d3);
        dst_arr[0] = IW'(d0);
        dst_arr[1] = IW'(d1);
        dst_arr[2] = IW'(d2);
        dst_arr[3] = IW'(d3);
        for (int i = 0; i < N; i++) dst[i*IW +: IW] = dst_arr[i];
    endtask

    task automatic applyStimulus(input logic [N-1:0] mask, input int d0, input int d1,
                                 input int d2, input int d3);
        set_dst(d0, d1, d2, d3);
        req = mask;
        issue(mask, $countones(mask));
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] e_rd, input logic [N-1:0] e_wr,
                               input logic [N-1:0] e_done, input logic e_err, input logic e_busy);
        tests++;
        if (rd_en !== e_rd || wr_en !== e_wr || done !== e_done || err !== e_err || busy !== e_busy) begin
            failures++;
            $display("[TB] FAIL %s: got rd=%b wr=%b done=%b err=%b busy=%b, need rd=%b wr=%b done=%b err=%b busy=%b",
                     name, rd_en, wr_en, done, err, busy, e_rd, e_wr, e_done, e_err, e_busy);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (req == '0 && !busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s_timeout: busy=%b req=%b pending=%0d, need idle with nothing pending",
                     name, busy, req, exp_q.size());
            exp_q.delete();
            req = '0;
        end
    endtask

    task automatic monitor();
        exp_t         e;
        logic [N-1:0] er, ew, ed;
        logic [N-1:0] prev_rd;
        prev_rd = '0;
        forever begin
            @(negedge clk);
            if (rd_en != '0 || wr_en != '0) begin
                tests++;
                if (!$onehot(rd_en) || !$onehot(wr_en) || prev_rd != '0) begin
                    failures++;
                    $display("[TB] FAIL bus_ownership: rd=%b wr=%b prev_rd=%b, need one-hot pair after a dead cycle",
                             rd_en, wr_en, prev_rd);
                end
            end
            prev_rd = rd_en;
            if (done != '0) begin
                drop_pending = drop_pending | done;
                done_cyc.push_back(cyc);
                tests++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_done: done=%b err=%b, need no completion", done, err);
                end else begin
                    e  = exp_q.pop_front();
                    er = '0;
                    ew = '0;
                    ed = '0;
                    ed[e.src] = 1'b1;
                    if (!e.rej) begin
                        er[e.src] = 1'b1;
                        ew[e.dst] = 1'b1;
                    end
                    if (done !== ed || rd_en !== er || wr_en !== ew || err !== e.rej || busy !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL xfer_src%0d: got rd=%b wr=%b done=%b err=%b busy=%b, need rd=%b wr=%b done=%b err=%b busy=1",
                                 e.src, rd_en, wr_en, done, err, busy, er, ew, ed, e.rej);
                    end
                    if (!e.rej) begin
                        tests++;
                        if (bus_val !== ref_mem[e.src]) begin
                            failures++;
                            $display("[TB] FAIL bus_data_src%0d: got %h, need %h", e.src, bus_val, ref_mem[e.src]);
                        end
                        ref_mem[e.dst] = ref_mem[e.src];
                    end else begin
                        tests++;
                        if (bus_driven !== 1'b0) begin
                            failures++;
                            $display("[TB] FAIL reject_bus_z: bus driven=%b, need 0", bus_driven);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int base;
        reset        = 1'b0;
        req          = '0;
        dst          = '0;
        load_en      = 1'b0;
        load_idx     = '0;
        load_val     = '0;
        drop_pending = '0;
        sticky       = 0;
        model_ptr    = 0;
        tests        = 0;
        failures     = 0;
        set_dst(0, 0, 0, 0);

        fork
            monitor();
        join_none

        load_unit(0, 16'h1111);
        load_unit(1, 16'h2222);
        load_unit(2, 16'h3333);
        load_unit(3, 16'h4444);

        // Reset held with every requester asking, then release into round-robin.
        set_dst(1, 2, 3, 0);
        req = 4'hF;
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            checkOutput("reset_hold", '0, '0, '0, 1'b0, 1'b0);
        end
        step();
        reset  = 1'b1;
        sticky = 1;
        issue(4'hF, 6);
        base = done_cyc.size();
        for (int n = 0; n < 40 && done_cyc.size() < base + 6; n++) step();
        req          = '0;
        sticky       = 0;
        drop_pending = '0;
        tests++;
        if (done_cyc.size() < base + 6) begin
            failures++;
            $display("[TB] FAIL fair_count: got %0d grants, need 6", done_cyc.size() - base);
        end else begin
            for (int k = base + 1; k < base + 6; k++) begin
                tests++;
                if (done_cyc[k] - done_cyc[k-1] != 2) begin
                    failures++;
                    $display("[TB] FAIL fair_spacing: got gap %0d cycles, need 2", done_cyc[k] - done_cyc[k-1]);
                end
            end
        end
        wait_idle("fair");

        // Single transfer 1 -> 3 carrying A5A5.
        load_unit(1, 16'hA5A5);
        load_unit(3, 16'h0000);
        applyStimulus(4'b0010, 0, 3, 0, 0);
        @(negedge clk);
        checkOutput("single_pre", '0, '0, '0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        checkOutput("single_xfer", 4'b0010, 4'b1000, 4'b0010, 1'b0, 1'b1);
        step();
        @(negedge clk);
        checkOutput("single_turn", '0, '0, '0, 1'b0, 1'b1);
        step();
        @(negedge clk);
        checkOutput("single_idle", '0, '0, '0, 1'b0, 1'b0);
        tests++;
        if (unit_q[3] !== 16'hA5A5) begin
            failures++;
            $display("[TB] FAIL single_data: unit3=%h, need a5a5", unit_q[3]);
        end
        wait_idle("single");

        // Requester 2 targets itself.
        applyStimulus(4'b0100, 0, 0, 2, 0);
        step();
        @(negedge clk);
        checkOutput("reject_xfer", '0, '0, 4'b0100, 1'b1, 1'b1);
        step();
        @(negedge clk);
        checkOutput("reject_turn", '0, '0, '0, 1'b0, 1'b1);
        wait_idle("reject");

        // Requester 2 appears only during the TURN after requester 1.
        applyStimulus(4'b0010, 0, 0, 0, 0);
        step();
        step();
        req[2]     = 1'b1;
        dst_arr[2] = 2'd3;
        dst[2*IW +: IW] = dst_arr[2];
        issue(4'b0100, 1);
        @(negedge clk);
        checkOutput("late_turn", '0, '0, '0, 1'b0, 1'b1);
        step();
        @(negedge clk);
        checkOutput("late_xfer", 4'b0100, 4'b1000, 4'b0100, 1'b0, 1'b1);
        wait_idle("late");

        // Reset lands on the edge that would start requester 3's transfer.
        load_unit(0, 16'h0BAD);
        set_dst(0, 0, 0, 0);
        req   = 4'b1000;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_entry", '0, '0, '0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        checkOutput("rst_mid_hold", '0, '0, '0, 1'b0, 1'b0);
        step();
        exp_q.delete();
        model_ptr = 0;
        reset     = 1'b1;
        applyStimulus(4'b1001, 1, 0, 0, 2);
        wait_idle("rst_mid");
        tests++;
        if (unit_q[0] !== 16'h0BAD) begin
            failures++;
            $display("[TB] FAIL rst_mid_dst: unit0=%h, need 0bad", unit_q[0]);
        end

        // Randomized request sets and destinations.
        for (int r = 0; r < 30; r++) begin
            applyStimulus(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            wait_idle("random");
        end

        for (int j = 0; j < N; j++) begin
            tests++;
            if (unit_q[j] !== ref_mem[j]) begin
                failures++;
                $display("[TB] FAIL final_unit%0d: got %h, need %h", j, unit_q[j], ref_mem[j]);
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL leftover: %0d expected transfers never completed, need 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
